imem_fetch_arbiter: RTL and testbench

Sequences a byte-wide, single-port instruction SRAM (1-cycle read latency) between two requesters: the core fetch port (32-bit little-endian instruction reads) and a program-load port (byte writes from the loader/debug path). Each fetch is built from four sequential byte reads. Writes are single-cycle. Sits between the PC/fetch stage and the instruction SRAM, replacing direct combinational reads.

---
 rtl/imem_fetch_arbiter.sv | 151 +++++++++++++++
 tb/tb_imem_fetch_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_arbiter.sv
// Arbitrates a byte-wide single-port instruction SRAM between 32-bit core fetches
// (built from four sequential byte reads) and single-cycle program-load byte writes.
module imem_fetch_arbiter #(
    parameter int AW    = 11,
    parameter int DEPTH = 2048
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_req_valid,
    output logic          fetch_req_ready,
    input  logic [31:0]   fetch_addr,
    output logic          fetch_rsp_valid,
    input  logic          fetch_rsp_ready,
    output logic [31:0]   fetch_instr,
    output logic          fetch_err,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [AW-1:0] load_addr,
    input  logic [7:0]    load_data,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic          busy,
    output logic [AW:0]   load_count
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_LAST, S_RESP} state_e;
    typedef enum logic {GRANT_LOAD, GRANT_FETCH} grant_e;

    localparam logic [31:0] FETCH_MAX  = 32'(DEPTH - 4);
    localparam logic [AW:0] LOAD_LIMIT = (AW+1)'(DEPTH);
    localparam logic [AW:0] COUNT_MAX  = '1;

    state_e        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [AW-1:0] base_q, base_d;
    logic [31:0]   instr_q, instr_d;
    logic          err_q, err_d;
    logic [AW:0]   count_q, count_d;
    grant_e        last_q, last_d;

    logic grant_fetch, grant_load, fetch_bad, load_in_range;

    // On a tie the requester that did not win last time is served.
    assign grant_fetch   = fetch_req_valid && (!load_valid || last_q == GRANT_LOAD);
    assign grant_load    = load_valid && (!fetch_req_valid || last_q == GRANT_FETCH);
    assign fetch_bad     = (fetch_addr[1:0] != 2'b00) || (fetch_addr > FETCH_MAX);
    assign load_in_range = {1'b0, load_addr} < LOAD_LIMIT;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            base_q  <= '0;
            instr_q <= '0;
            err_q   <= 1'b0;
            count_q <= '0;
            last_q  <= GRANT_LOAD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            instr_q <= instr_d;
            err_q   <= err_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        base_d          = base_q;
        instr_d         = instr_q;
        err_d           = err_q;
        count_d         = count_q;
        last_d          = last_q;
        fetch_req_ready = 1'b0;
        load_ready      = 1'b0;
        mem_en          = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;

        unique case (state_q)
            S_IDLE: begin
                fetch_req_ready = grant_fetch;
                load_ready      = grant_load;
                if (grant_load) begin
                    last_d = GRANT_LOAD;
                    if (load_in_range) begin
                        mem_en    = 1'b1;
                        mem_we    = 1'b1;
                        mem_addr  = load_addr;
                        mem_wdata = load_data;
                        if (count_q != COUNT_MAX) begin
                            count_d = count_q + (AW+1)'(1);
                        end
                    end
                end else if (grant_fetch) begin
                    last_d = GRANT_FETCH;
                    base_d = fetch_addr[AW-1:0];
                    cnt_d  = 2'd0;
                    if (fetch_bad) begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                        instr_d = '0;
                    end else begin
                        state_d = S_READ;
                        err_d   = 1'b0;
                    end
                end
            end
            S_READ: begin
                mem_en   = 1'b1;
                mem_addr = base_q + {{(AW-2){1'b0}}, cnt_q};
                // Bytes arrive lowest first; shifting in from the top leaves byte0 at [7:0].
                if (cnt_q != 2'd0) begin
                    instr_d = {mem_rdata, instr_q[31:8]};
                end
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = S_LAST;
                end
            end
            S_LAST: begin
                instr_d = {mem_rdata, instr_q[31:8]};
                state_d = S_RESP;
            end
            S_RESP: begin
                if (fetch_rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign fetch_rsp_valid = (state_q == S_RESP);
    assign fetch_instr     = instr_q;
    assign fetch_err       = err_q;
    assign busy            = (state_q != S_IDLE);
    assign load_count      = count_q;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Self-checking bench for imem_fetch_arbiter: directed scenarios plus random traffic
// compared every cycle against a transaction-level reference model.
module tb_imem_fetch_arbiter;

    localparam int AW        = 12;
    localparam int DEPTH     = 2048;
    localparam int MEMSZ     = 1 << AW;
    localparam int COUNT_MAX = (1 << (AW + 1)) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_req_valid;
    logic          fetch_req_ready;
    logic [31:0]   fetch_addr;
    logic          fetch_rsp_valid;
    logic          fetch_rsp_ready;
    logic [31:0]   fetch_instr;
    logic          fetch_err;
    logic          load_valid;
    logic          load_ready;
    logic [AW-1:0] load_addr;
    logic [7:0]    load_data;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic          busy;
    logic [AW:0]   load_count;

    always #5 clk = ~clk;

    imem_fetch_arbiter #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_req_valid (fetch_req_valid),
        .fetch_req_ready (fetch_req_ready),
        .fetch_addr      (fetch_addr),
        .fetch_rsp_valid (fetch_rsp_valid),
        .fetch_rsp_ready (fetch_rsp_ready),
        .fetch_instr     (fetch_instr),
        .fetch_err       (fetch_err),
        .load_valid      (load_valid),
        .load_ready      (load_ready),
        .load_addr       (load_addr),
        .load_data       (load_data),
        .mem_en          (mem_en),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .busy            (busy),
        .load_count      (load_count)
    );

    // Byte-wide SRAM with one cycle of read latency.
    logic [7:0] sram [MEMSZ];
    always @(posedge clk) begin
        if (mem_en && mem_we) sram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= sram[mem_addr];
    end

    // Reference model: shadow memory plus the outstanding fetch described by its
    // accept cycle, base, expected result and the cycle its response becomes visible.
    logic [7:0]    shadow [MEMSZ];
    bit            m_busy;
    bit            m_last_fetch;
    bit            m_err;
    int            m_count;
    int            m_accept;
    int            m_rsp_at;
    logic [AW-1:0] m_base;
    logic [31:0]   m_instr;

    int cyc;
    int errors;
    int checks;

    logic          s_fready, s_lready, s_en, s_we, s_rv, s_err, s_busy;
    logic [AW-1:0] s_addr;
    logic [31:0]   s_instr;
    logic [AW:0]   s_count;

    logic [31:0] bad_addrs [3] = '{32'd2, 32'd2048, 32'h8000_0000};
    logic [7:0]  t1_bytes  [4] = '{8'h13, 8'h05, 8'h00, 8'h00};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: sample outputs at negedge, compare to the model, advance the model
    // by what the coming edge does, then return just after the edge.
    task automatic cycle();
        logic          gf, gl, in_rng, e_en, e_we, e_rv;
        logic [AW-1:0] e_addr, b;
        logic [7:0]    e_wdata;
        @(negedge clk);
        s_fready = fetch_req_ready;
        s_lready = load_ready;
        s_en     = mem_en;
        s_we     = mem_we;
        s_addr   = mem_addr;
        s_rv     = fetch_rsp_valid;
        s_instr  = fetch_instr;
        s_err    = fetch_err;
        s_busy   = busy;
        s_count  = load_count;

        gf = 1'b0; gl = 1'b0; e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
        in_rng = (int'(load_addr) < DEPTH);
        if (!m_busy) begin
            if (fetch_req_valid && load_valid) begin
                gf = !m_last_fetch;
                gl = m_last_fetch;
            end else begin
                gf = fetch_req_valid;
                gl = load_valid;
            end
            if (gl && in_rng) begin
                e_en = 1'b1; e_we = 1'b1; e_addr = load_addr; e_wdata = load_data;
            end
        end else if (!m_err && cyc > m_accept && cyc <= m_accept + 4) begin
            e_en   = 1'b1;
            e_addr = m_base + AW'(cyc - m_accept - 1);
        end
        e_rv = m_busy && (cyc >= m_rsp_at);

        check("fetch_req_ready", s_fready, gf);
        check("load_ready", s_lready, gl);
        check("mem_en", s_en, e_en);
        check("mem_we", s_we, e_we);
        check("mem_addr", s_addr, e_addr);
        if (e_we) check("mem_wdata", mem_wdata, e_wdata);
        check("fetch_rsp_valid", s_rv, e_rv);
        check("busy", s_busy, m_busy);
        check("load_count", s_count, m_count);
        if (e_rv) begin
            check("fetch_instr", s_instr, m_instr);
            check("fetch_err", s_err, m_err);
        end

        if (gl && in_rng) shadow[load_addr] = load_data;
        if (!rst) begin
            m_busy = 0; m_last_fetch = 0; m_count = 0;
        end else begin
            if (gl) begin
                m_last_fetch = 0;
                if (in_rng && m_count < COUNT_MAX) m_count++;
            end
            if (gf) begin
                m_last_fetch = 1;
                m_busy   = 1;
                m_accept = cyc;
                m_base   = fetch_addr[AW-1:0];
                m_err    = (fetch_addr[1:0] != 2'b00) || (fetch_addr > 32'(DEPTH - 4));
                b        = m_base;
                m_instr  = m_err ? 32'h0 : {shadow[b+3], shadow[b+2], shadow[b+1], shadow[b]};
                m_rsp_at = cyc + (m_err ? 1 : 6);
            end
            if (e_rv && fetch_rsp_ready) m_busy = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        int n;
        fetch_req_valid = 0; load_valid = 0; fetch_rsp_ready = 1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (s_busy && n < 20);
        if (s_busy) check("drain timeout", s_busy, 0);
    endtask

    task automatic do_reset();
        fetch_req_valid = 0; load_valid = 0; rst = 0;
        cycle();
        rst = 1;
    endtask

    function automatic logic [31:0] rand_fetch_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7) return 32'($urandom_range(0, DEPTH / 4 - 1)) << 2;
        if (r == 7) return 32'($urandom_range(0, DEPTH - 1)) | 32'd1;
        if (r == 8) return 32'(DEPTH + 4 * $urandom_range(0, 3));
        return $urandom | 32'h8000_0000;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int n, hs, c0;
        logic en_seen;
        logic [31:0] instr0;

        errors = 0; checks = 0; cyc = 0;
        m_busy = 0; m_last_fetch = 0; m_count = 0; m_err = 0;
        m_accept = 0; m_rsp_at = 0; m_base = '0; m_instr = '0;
        rst = 0; fetch_req_valid = 0; fetch_addr = '0; fetch_rsp_ready = 1;
        load_valid = 0; load_addr = '0; load_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset rsp_valid", fetch_rsp_valid, 0);
        check("reset instr", fetch_instr, 0);
        check("reset err", fetch_err, 0);
        check("reset load_count", load_count, 0);
        check("reset busy", busy, 0);
        rst = 1;

        // Fill the whole array through the load port so every byte has a known value.
        for (int i = 0; i < DEPTH; i++) begin
            load_valid = 1; load_addr = AW'(i); load_data = 8'($urandom);
            cycle();
        end
        do_reset();

        // Program then fetch a known instruction word at address 0.
        for (int i = 0; i < 4; i++) begin
            load_valid = 1; load_addr = AW'(i); load_data = t1_bytes[i];
            cycle();
            check("t1 load_ready", s_lready, 1);
        end
        load_valid = 0;
        cycle();
        check("t1 load_count", s_count, 4);
        fetch_req_valid = 1; fetch_addr = 0;
        cycle();
        check("t1 accept", s_fready, 1);
        fetch_req_valid = 0;
        n = 0;
        while (n < 20) begin
            cycle();
            n++;
            if (n <= 4) begin
                check("t1 read en", s_en, 1);
                check("t1 read addr", s_addr, n - 1);
            end
            if (s_rv) break;
        end
        check("t1 latency", n, 6);
        check("t1 instr", s_instr, 32'h0000_0513);
        check("t1 err", s_err, 0);

        // Tie immediately after reset: fetch first, then the waiting load.
        do_reset();
        fetch_req_valid = 1; fetch_addr = 16; fetch_rsp_ready = 1;
        load_valid = 1; load_addr = 100; load_data = 8'hA5;
        cycle();
        check("t2 fetch wins tie", s_fready, 1);
        check("t2 load waits", s_lready, 0);
        fetch_req_valid = 0;
        hs = -1; n = 0;
        while (n < 20) begin
            cycle();
            n++;
            if (s_lready) break;
            if (s_rv) hs = n;
        end
        check("t2 handshake cycle", hs, 6);
        check("t2 load after handshake", n, hs + 1);
        check("t2 load granted", s_lready, 1);
        load_valid = 0;

        // Bad fetch addresses answer with an error one cycle later, no SRAM access.
        foreach (bad_addrs[k]) begin
            fetch_req_valid = 1; fetch_addr = bad_addrs[k]; fetch_rsp_ready = 1;
            cycle();
            check("t3 accept", s_fready, 1);
            en_seen = s_en;
            fetch_req_valid = 0;
            n = 0;
            while (n < 20) begin
                cycle();
                n++;
                en_seen |= s_en;
                if (s_rv) break;
            end
            check("t3 latency", n, 1);
            check("t3 err", s_err, 1);
            check("t3 instr", s_instr, 0);
            check("t3 no mem_en", en_seen, 0);
            cycle();
        end

        // Response stalled by the consumer stays stable and blocks both requesters.
        fetch_req_valid = 1; fetch_addr = 8; fetch_rsp_ready = 0;
        cycle();
        fetch_req_valid = 0;
        n = 0;
        while (n < 20 && !s_rv) begin
            cycle();
            n++;
        end
        check("t4 response seen", s_rv, 1);
        instr0 = s_instr;
        fetch_req_valid = 1; fetch_addr = 12; load_valid = 1; load_addr = 200;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t4 hold valid", s_rv, 1);
            check("t4 hold instr", s_instr, instr0);
            check("t4 fetch blocked", s_fready, 0);
            check("t4 load blocked", s_lready, 0);
        end
        fetch_req_valid = 0; load_valid = 0; fetch_rsp_ready = 1;
        cycle();
        cycle();
        check("t4 idle after handshake", s_busy, 0);

        // Reset in the middle of a fetch abandons it.
        load_valid = 1; load_addr = 300; load_data = 8'h11;
        cycle();
        load_valid = 0;
        fetch_req_valid = 1; fetch_addr = 4;
        cycle();
        fetch_req_valid = 0;
        cycle();
        cycle();
        rst = 0;
        cycle();
        check("t5 read cnt2 addr", s_addr, 6);
        rst = 1; fetch_req_valid = 1; fetch_addr = 0;
        cycle();
        check("t5 idle", s_busy, 0);
        check("t5 rsp_valid", s_rv, 0);
        check("t5 mem_en", s_en, 0);
        check("t5 load_count", s_count, 0);
        check("t5 instr", s_instr, 0);
        check("t5 fetch_ready", s_fready, 1);
        drain();

        // Top in-range byte is written; the next address is accepted and dropped.
        c0 = int'(s_count);
        load_valid = 1; load_addr = AW'(DEPTH - 1); load_data = 8'h5A;
        cycle();
        check("t6 in-range en", s_en, 1);
        load_addr = AW'(DEPTH);
        cycle();
        check("t6 count +1", s_count, c0 + 1);
        check("t6 oor ready", s_lready, 1);
        check("t6 oor en", s_en, 0);
        load_valid = 0;
        cycle();
        check("t6 count unchanged", s_count, c0 + 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst             = ($urandom_range(0, 399) != 0);
            fetch_req_valid = ($urandom_range(0, 2) != 0);
            fetch_addr      = rand_fetch_addr();
            fetch_rsp_ready = ($urandom_range(0, 9) < 7);
            load_valid      = $urandom_range(0, 1) != 0;
            load_addr       = ($urandom_range(0, 7) == 0) ? AW'(DEPTH - 1) : AW'($urandom_range(0, DEPTH + 63));
            load_data       = 8'($urandom);
            cycle();
        end
        rst = 1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
